i2c_regf_burst: RTL and testbench

Parametrised I2C target with an on-chip register bank, the next generation of the `tt_um_i2c_regf` slave/register-file pair. SCL and SDA are oversampled on the system clock rather than used as clocks, and the block adds a register pointer with burst auto-increment, repeated-START support and a parallel view of all registers. It sits directly behind the chip's I2C pads. It exposes the register bank to core logic as a flat bus plus a one-cycle write strobe.

---
 rtl/i2c_regf_burst.sv | 206 ++++++++++++++++++++
 tb/tb_i2c_regf_burst.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_regf_burst.sv
// I2C target with an oversampled bus front end and a register bank.
// A burst pointer auto-increments; all registers are exposed in parallel.
module i2c_regf_burst #(
  parameter logic [6:0] DEVICE_ADDR = 7'h2A,
  parameter int         REG_COUNT   = 16,
  parameter int         PTR_WIDTH   = 4,
  parameter bit         AUTO_INC    = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   scl_in,
  input  logic                   sda_in,
  output logic                   sda_oe,
  output logic [REG_COUNT*8-1:0] reg_flat,
  output logic                   wr_strobe,
  output logic [PTR_WIDTH-1:0]   wr_addr,
  output logic                   busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  localparam logic [PTR_WIDTH:0] RC =
    (PTR_WIDTH+1)'(REG_COUNT);
  localparam logic [PTR_WIDTH-1:0] LAST =
    PTR_WIDTH'(REG_COUNT-1);

  state_t               state_q;
  logic [2:0]           scl_q, sda_q;
  logic [2:0]           cnt_q;
  logic [7:0]           sh_q;
  logic [PTR_WIDTH-1:0] ptr_q;
  logic                 ack_q, rw_q;
  logic                 sda_oe_q, busy_q;
  logic                 wr_strobe_q;
  logic [PTR_WIDTH-1:0] wr_addr_q;
  logic [7:0]           regs_q [REG_COUNT];

  logic                 scl_rise, scl_fall, scl_hi;
  logic                 start_c, stop_c;
  logic [7:0]           byte_d, rd_byte;
  logic [PTR_WIDTH-1:0] ptr_inc_d;
  logic                 in_range;

  // [1] is the synchronised level, [2] the delayed copy for edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign scl_hi   = scl_q[1] & scl_q[2];
  assign start_c  = scl_hi & ~sda_q[1] & sda_q[2];
  assign stop_c   = scl_hi & sda_q[1] & ~sda_q[2];

  assign byte_d   = {sh_q[6:0], sda_q[1]};
  assign in_range = {1'b0, ptr_q} < RC;

  always_comb begin
    ptr_inc_d = ptr_q;
    if (AUTO_INC)
      ptr_inc_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
  end

  always_comb begin
    rd_byte = 8'hFF;
    for (int i = 0; i < REG_COUNT; i++)
      if (ptr_q == PTR_WIDTH'(i)) rd_byte = regs_q[i];
  end

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_flat
    assign reg_flat[8*g +: 8] = regs_q[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      ptr_q       <= '0;
      ack_q       <= 1'b0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      for (int i = 0; i < REG_COUNT; i++)
        regs_q[i] <= 8'h00;
    end else begin
      wr_strobe_q <= 1'b0;
      if (start_c) begin
        state_q  <= ADDR;
        cnt_q    <= '0;
        busy_q   <= 1'b1;
        sda_oe_q <= 1'b0;
        ack_q    <= 1'b0;
      end else if (stop_c) begin
        state_q  <= IDLE;
        busy_q   <= 1'b0;
        sda_oe_q <= 1'b0;
        ack_q    <= 1'b0;
      end else begin
        case (state_q)
          ADDR, PTR, WDATA: begin
            if (scl_rise) begin
              sh_q  <= byte_d;
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                unique case (1'b1)
                  state_q == ADDR: begin
                    rw_q <= byte_d[0];
                    if (byte_d[7:1] == DEVICE_ADDR &&
                        byte_d[7:1] != 7'h00)
                      state_q <= ADDR_ACK;
                    else
                      state_q <= IGNORE;
                  end
                  state_q == PTR: begin
                    ptr_q   <= byte_d[PTR_WIDTH-1:0];
                    state_q <= PTR_ACK;
                  end
                  default: begin
                    if (in_range) begin
                      for (int i = 0; i < REG_COUNT; i++)
                        if (ptr_q == PTR_WIDTH'(i))
                          regs_q[i] <= byte_d;
                      wr_strobe_q <= 1'b1;
                      wr_addr_q   <= ptr_q;
                    end
                    ptr_q   <= ptr_inc_d;
                    state_q <= WDATA_ACK;
                  end
                endcase
              end
            end
          end
          // First fall starts the ACK slot, second fall ends it
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_q) begin
                ack_q    <= 1'b1;
                sda_oe_q <= 1'b1;
              end else begin
                ack_q    <= 1'b0;
                sda_oe_q <= 1'b0;
                cnt_q    <= '0;
                if (state_q == ADDR_ACK && rw_q) begin
                  state_q  <= RDATA;
                  sh_q     <= rd_byte;
                  sda_oe_q <= ~rd_byte[7];
                end else if (state_q == ADDR_ACK) begin
                  state_q <= PTR;
                end else begin
                  state_q <= WDATA;
                end
              end
            end
          end
          RDATA: begin
            if (scl_fall) begin
              if (cnt_q == 3'd7) begin
                cnt_q    <= '0;
                sda_oe_q <= 1'b0;
                state_q  <= RDATA_ACK;
              end else begin
                cnt_q    <= cnt_q + 3'd1;
                sh_q     <= {sh_q[6:0], 1'b1};
                sda_oe_q <= ~sh_q[6];
              end
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_q[1]) begin
                state_q <= IGNORE;
              end else begin
                ptr_q <= ptr_inc_d;
                ack_q <= 1'b1;
              end
            end else if (scl_fall && ack_q) begin
              ack_q    <= 1'b0;
              state_q  <= RDATA;
              sh_q     <= rd_byte;
              sda_oe_q <= ~rd_byte[7];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_i2c_regf_burst.sv
// Directed bench: an I2C controller model drives the target through
// burst writes, repeated-START reads, mismatches, aborts and resets.
module tb_i2c_regf_burst;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_in;
  logic        sda_oe;
  logic [95:0] reg_flat;
  logic        wr_strobe;
  logic [3:0]  wr_addr;
  logic        busy;

  int          pass_n = 0;
  int          total_n = 0;
  int          strb_n = 0;
  logic [3:0]  strb_addr [$];
  bit          oe_seen = 1'b0;
  logic [95:0] exp_flat = '0;

  always #5 clk = ~clk;

  assign sda_in = sda_m & ~sda_oe;

  i2c_regf_burst #(
    .DEVICE_ADDR(7'h2A),
    .REG_COUNT(12),
    .PTR_WIDTH(4),
    .AUTO_INC(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .scl_in(scl),
    .sda_in(sda_in),
    .sda_oe(sda_oe),
    .reg_flat(reg_flat),
    .wr_strobe(wr_strobe),
    .wr_addr(wr_addr),
    .busy(busy)
  );

  always @(negedge clk) begin
    if (wr_strobe) begin
      strb_n++;
      strb_addr.push_back(wr_addr);
    end
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wclk(4);
    scl = 1'b1;   wclk(8);
    sda_m = 1'b0; wclk(8);
    scl = 1'b0;   wclk(4);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wclk(4);
    scl = 1'b1;   wclk(8);
    sda_m = 1'b1; wclk(8);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;  wclk(4);
    scl = 1'b1; wclk(8);
    scl = 1'b0; wclk(4);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wclk(4);
    scl = 1'b1;   wclk(4);
    b = sda_in;   wclk(4);
    scl = 1'b0;   wclk(4);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1;
    wclk(3);
    total_n++;
    if (sda_oe !== 1'b0) $display("FAIL rst_sda_oe got=%0b exp=0", sda_oe);
    else pass_n++;
    total_n++;
    if (busy !== 1'b0) $display("FAIL rst_busy got=%0b exp=0", busy);
    else pass_n++;
    total_n++;
    if (reg_flat !== 96'h0) $display("FAIL rst_regs got=%h exp=0", reg_flat);
    else pass_n++;
    total_n++;
    if (wr_strobe !== 1'b0 || wr_addr !== 4'h0)
      $display("FAIL rst_wr got=%0b/%h exp=0/0", wr_strobe, wr_addr);
    else pass_n++;
    rst_n = 1'b1;
    wclk(4);
  endtask

  task automatic test_burst_write();
    logic a0, a1, a2, a3;
    strb_n = 0; strb_addr.delete();
    bus_start();
    write_byte(8'h54, a0);
    write_byte(8'h03, a1);
    total_n++;
    if (busy !== 1'b1) $display("FAIL bw_busy got=%0b exp=1", busy);
    else pass_n++;
    write_byte(8'hA5, a2);
    write_byte(8'h5A, a3);
    bus_stop();
    exp_flat[24 +: 8] = 8'hA5;
    exp_flat[32 +: 8] = 8'h5A;
    total_n++;
    if ({a0, a1, a2, a3} !== 4'b0000)
      $display("FAIL bw_acks got=%b exp=0000", {a0, a1, a2, a3});
    else pass_n++;
    total_n++;
    if (strb_n !== 2) $display("FAIL bw_strobes got=%0d exp=2", strb_n);
    else pass_n++;
    total_n++;
    if (strb_n == 2 && (strb_addr[0] !== 4'h3 || strb_addr[1] !== 4'h4))
      $display("FAIL bw_wr_addr got=%h,%h exp=3,4", strb_addr[0], strb_addr[1]);
    else pass_n++;
    total_n++;
    if (reg_flat !== exp_flat)
      $display("FAIL bw_regs got=%h exp=%h", reg_flat, exp_flat);
    else pass_n++;
    total_n++;
    if (busy !== 1'b0) $display("FAIL bw_busy_end got=%0b exp=0", busy);
    else pass_n++;
  endtask

  task automatic test_wrap_read();
    logic a;
    logic [7:0] d0, d1;
    bus_start();
    write_byte(8'h54, a);
    write_byte(8'h0B, a);
    write_byte(8'h3C, a);
    write_byte(8'hC3, a);
    bus_stop();
    exp_flat[88 +: 8] = 8'h3C;
    exp_flat[0 +: 8]  = 8'hC3;
    total_n++;
    if (reg_flat !== exp_flat)
      $display("FAIL wr_wrap_regs got=%h exp=%h", reg_flat, exp_flat);
    else pass_n++;
    bus_start();
    write_byte(8'h54, a);
    write_byte(8'h0B, a);
    bus_start();
    write_byte(8'h55, a);
    total_n++;
    if (a !== 1'b0) $display("FAIL rd_addr_ack got=%0b exp=0", a);
    else pass_n++;
    read_byte(d0, 1'b0);
    read_byte(d1, 1'b1);
    total_n++;
    if (d0 !== 8'h3C) $display("FAIL rd_byte0 got=%h exp=3c", d0);
    else pass_n++;
    total_n++;
    if (d1 !== 8'hC3) $display("FAIL rd_wrap_byte1 got=%h exp=c3", d1);
    else pass_n++;
    wclk(4);
    total_n++;
    if (sda_oe !== 1'b0) $display("FAIL rd_nack_release got=%0b exp=0", sda_oe);
    else pass_n++;
    bus_stop();
  endtask

  task automatic test_out_of_range();
    logic a;
    logic [7:0] d0, d1;
    strb_n = 0;
    bus_start();
    write_byte(8'h54, a);
    write_byte(8'h0D, a);
    write_byte(8'h77, a);
    bus_stop();
    total_n++;
    if (a !== 1'b0) $display("FAIL oor_wr_ack got=%0b exp=0", a);
    else pass_n++;
    total_n++;
    if (strb_n !== 0 || reg_flat !== exp_flat)
      $display("FAIL oor_wr_discard got=%0d/%h exp=0/%h", strb_n, reg_flat, exp_flat);
    else pass_n++;
    bus_start();
    write_byte(8'h54, a);
    write_byte(8'h0D, a);
    bus_start();
    write_byte(8'h55, a);
    read_byte(d0, 1'b1);
    bus_stop();
    total_n++;
    if (d0 !== 8'hFF) $display("FAIL oor_rd got=%h exp=ff", d0);
    else pass_n++;
    bus_start();
    write_byte(8'h54, a);
    write_byte(8'h0F, a);
    bus_start();
    write_byte(8'h55, a);
    read_byte(d0, 1'b0);
    read_byte(d1, 1'b1);
    bus_stop();
    total_n++;
    if (d0 !== 8'hFF || d1 !== 8'hC3)
      $display("FAIL oor_pow2_wrap got=%h,%h exp=ff,c3", d0, d1);
    else pass_n++;
  endtask

  task automatic test_addr_mismatch();
    logic a0, a1;
    strb_n = 0; oe_seen = 1'b0;
    bus_start();
    write_byte(8'h56, a0);
    total_n++;
    if (busy !== 1'b1) $display("FAIL mm_busy got=%0b exp=1", busy);
    else pass_n++;
    write_byte(8'h12, a1);
    total_n++;
    if ({a0, a1} !== 2'b11) $display("FAIL mm_nack got=%b exp=11", {a0, a1});
    else pass_n++;
    bus_stop();
    total_n++;
    if (oe_seen !== 1'b0) $display("FAIL mm_sda_oe got=%0b exp=0", oe_seen);
    else pass_n++;
    total_n++;
    if (busy !== 1'b0 || strb_n !== 0 || reg_flat !== exp_flat)
      $display("FAIL mm_end got=%0b/%0d/%h exp=0/0/%h", busy, strb_n, reg_flat, exp_flat);
    else pass_n++;
    bus_start();
    write_byte(8'h00, a0);
    bus_stop();
    total_n++;
    if (a0 !== 1'b1) $display("FAIL gen_call_nack got=%0b exp=1", a0);
    else pass_n++;
  endtask

  task automatic test_abort();
    logic a;
    strb_n = 0; strb_addr.delete();
    bus_start();
    write_byte(8'h54, a);
    write_byte(8'h05, a);
    write_bit(1'b0); write_bit(1'b0); write_bit(1'b0);
    write_bit(1'b1); write_bit(1'b0);
    bus_stop();
    total_n++;
    if (strb_n !== 0 || reg_flat !== exp_flat || busy !== 1'b0)
      $display("FAIL abort got=%0d/%h/%0b exp=0/%h/0", strb_n, reg_flat, busy, exp_flat);
    else pass_n++;
    bus_start();
    write_byte(8'h54, a);
    write_byte(8'h05, a);
    write_byte(8'h11, a);
    bus_stop();
    exp_flat[40 +: 8] = 8'h11;
    total_n++;
    if (strb_n !== 1 || strb_addr[0] !== 4'h5)
      $display("FAIL abort_retry_strobe got=%0d exp=1 at 5", strb_n);
    else pass_n++;
    total_n++;
    if (reg_flat !== exp_flat)
      $display("FAIL abort_retry_regs got=%h exp=%h", reg_flat, exp_flat);
    else pass_n++;
  endtask

  task automatic test_reset_mid_read();
    logic a;
    bus_start();
    write_byte(8'h54, a);
    write_byte(8'h04, a);
    bus_start();
    write_byte(8'h55, a);
    total_n++;
    if (sda_oe !== 1'b1) $display("FAIL mid_rd_drive got=%0b exp=1", sda_oe);
    else pass_n++;
    rst_n = 1'b0;
    #2;
    total_n++;
    if (sda_oe !== 1'b0 || busy !== 1'b0)
      $display("FAIL mid_rst_async got=%0b/%0b exp=0/0", sda_oe, busy);
    else pass_n++;
    total_n++;
    if (reg_flat !== 96'h0) $display("FAIL mid_rst_regs got=%h exp=0", reg_flat);
    else pass_n++;
    scl = 1'b1; sda_m = 1'b1;
    wclk(3);
    rst_n = 1'b1;
    wclk(4);
  endtask

  initial begin
    test_reset();
    test_burst_write();
    test_wrap_read();
    test_out_of_range();
    test_addr_mismatch();
    test_abort();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
